// File: rtl/neg_conv_pipe.sv
// Multi-lane pass/negate/abs converter with a valid/ready pipeline of STAGES slots.
// Results are one bit wider than the operands, so no mode can overflow.
module neg_conv_pipe #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int STAGES    = 2,
    parameter int SIGNED_IN = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [LANES*WIDTH-1:0]     data_i,
    input  logic [1:0]                 mode_i,
    input  logic [LANES-1:0]           neg_mask_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [LANES*(WIDTH+1)-1:0] data_o,
    output logic [LANES-1:0]           zero_o,
    output logic [LANES-1:0]           sign_o
);

    localparam int OW = WIDTH + 1;
    localparam int DW = LANES * OW;

    logic [DW-1:0]    conv_data;
    logic [LANES-1:0] conv_zero;
    logic [LANES-1:0] conv_sign;
    logic [WIDTH-1:0] lane_x;
    logic [OW-1:0]    lane_ext;
    logic [OW-1:0]    lane_neg;
    logic [OW-1:0]    lane_res;

    // Copy up to and including the first set bit, invert everything above.
    function automatic logic [OW-1:0] negate(input logic [OW-1:0] v);
        logic          seen;
        logic [OW-1:0] r;
        seen = 1'b0;
        r    = '0;
        for (int i = 0; i < OW; i++) begin
            r[i] = seen ? ~v[i] : v[i];
            seen = seen | v[i];
        end
        return r;
    endfunction

    always_comb begin
        conv_data = '0;
        conv_zero = '0;
        conv_sign = '0;
        lane_x    = '0;
        lane_ext  = '0;
        lane_neg  = '0;
        lane_res  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_x   = data_i[k*WIDTH +: WIDTH];
            lane_ext = (SIGNED_IN != 0) ? {lane_x[WIDTH-1], lane_x}
                                        : {1'b0, lane_x};
            lane_neg = negate(lane_ext);
            case (mode_i)
                2'b00:   lane_res = lane_ext;
                2'b01:   lane_res = lane_neg;
                2'b10:   lane_res = lane_ext[WIDTH] ? lane_neg : lane_ext;
                2'b11:   lane_res = neg_mask_i[k] ? lane_neg : lane_ext;
                default: lane_res = lane_ext;
            endcase
            conv_data[k*OW +: OW] = lane_res;
            conv_zero[k]          = (lane_res == '0);
            conv_sign[k]          = lane_res[WIDTH];
        end
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES:0]   nready;
    logic [STAGES-1:0] src_valid;
    logic [DW-1:0]     src_data [STAGES];
    logic [LANES-1:0]  src_zero [STAGES];
    logic [LANES-1:0]  src_sign [STAGES];
    logic [DW-1:0]     data_q   [STAGES];
    logic [DW-1:0]     data_d   [STAGES];
    logic [LANES-1:0]  zero_q   [STAGES];
    logic [LANES-1:0]  zero_d   [STAGES];
    logic [LANES-1:0]  sign_q   [STAGES];
    logic [LANES-1:0]  sign_d   [STAGES];
    logic              accept;
    logic              load;

    assign in_ready_o = nready[0] & ~flush_i & rst_n;
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        nready[STAGES] = out_ready_i;
        for (int s = STAGES - 1; s >= 0; s--) begin
            nready[s] = ~valid_q[s] | nready[s+1];
        end
    end

    always_comb begin
        src_valid[0] = accept;
        src_data[0]  = conv_data;
        src_zero[0]  = conv_zero;
        src_sign[0]  = conv_sign;
        for (int s = 1; s < STAGES; s++) begin
            src_valid[s] = valid_q[s-1];
            src_data[s]  = data_q[s-1];
            src_zero[s]  = zero_q[s-1];
            src_sign[s]  = sign_q[s-1];
        end
    end

    // Data regs only load when a beat actually moves in, so they act as clock enables.
    always_comb begin
        valid_d = valid_q;
        load    = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            load       = nready[s] & src_valid[s] & ~flush_i;
            valid_d[s] = flush_i ? 1'b0 : (nready[s] ? src_valid[s] : valid_q[s]);
            data_d[s]  = load ? src_data[s] : data_q[s];
            zero_d[s]  = load ? src_zero[s] : zero_q[s];
            sign_d[s]  = load ? src_sign[s] : sign_q[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                zero_q[s] <= '0;
                sign_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
                zero_q[s] <= zero_d[s];
                sign_q[s] <= sign_d[s];
            end
        end
    end

    assign out_valid_o = valid_q[STAGES-1];
    assign data_o      = data_q[STAGES-1];
    assign zero_o      = zero_q[STAGES-1];
    assign sign_o      = sign_q[STAGES-1];

endmodule

// File: tb/tb_neg_conv_pipe.sv
// Bench for neg_conv_pipe: signed and unsigned instances checked against an
// arithmetic model of the lane conversion and a beat queue.
module tb_neg_conv_pipe;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int ST = 2;
    localparam int OW = W + 1;
    localparam int DW = L * OW;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [L-1:0]  z;
        logic [L-1:0]  s;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [L*W-1:0] din = '0;
    logic [1:0]    mode = '0;
    logic [L-1:0]  mask = '0;

    logic          in_ready, out_valid;
    logic [DW-1:0] dout;
    logic [L-1:0]  zero, sign;
    logic          in_ready_u, out_valid_u;
    logic [DW-1:0] dout_u;
    logic [L-1:0]  zero_u, sign_u;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neg_conv_pipe #(.WIDTH(W), .LANES(L), .STAGES(ST), .SIGNED_IN(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data_i(din), .mode_i(mode), .neg_mask_i(mask),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_o(dout), .zero_o(zero), .sign_o(sign)
    );

    neg_conv_pipe #(.WIDTH(W), .LANES(L), .STAGES(ST), .SIGNED_IN(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_u),
        .data_i(din), .mode_i(mode), .neg_mask_i(mask),
        .out_valid_o(out_valid_u), .out_ready_i(out_ready),
        .data_o(dout_u), .zero_o(zero_u), .sign_o(sign_u)
    );

    // Integer-valued model: interpret each lane, decide the sign flip, wrap to W+1 bits.
    function automatic beat_t ref_beat(input logic [L*W-1:0] d, input logic [1:0] m,
                                       input logic [L-1:0] msk, input bit sgn);
        beat_t b;
        b = '0;
        for (int k = 0; k < L; k++) begin
            int          v;
            bit          neg;
            logic [31:0] r;
            logic [W-1:0] x;
            x = d[k*W +: W];
            v = int'(x);
            if (sgn && x[W-1]) v = v - (1 << W);
            case (m)
                2'd0:    neg = 1'b0;
                2'd1:    neg = 1'b1;
                2'd2:    neg = (v < 0);
                default: neg = msk[k];
            endcase
            r = neg ? -v : v;
            b.d[k*OW +: OW] = r[OW-1:0];
            b.z[k] = (r[OW-1:0] == '0);
            b.s[k] = r[OW-1];
        end
        return b;
    endfunction

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== '0 || zero !== '0 || sign !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h z=%b s=%b exp all 0",
                     out_valid, dout, zero, sign);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors;
        logic [31:0] vd [3];
        logic [1:0]  vm [3];
        logic [3:0]  vk [3];
        bit          vu [3];
        beat_t       ve [3];
        beat_t       got;
        vd[0] = 32'h807F0100; vm[0] = 2'b01; vk[0] = 4'b0000; vu[0] = 1'b0;
        vd[1] = 32'h000580FF; vm[1] = 2'b10; vk[1] = 4'b0000; vu[1] = 1'b0;
        vd[2] = 32'h1010FFFF; vm[2] = 2'b11; vk[2] = 4'b1010; vu[2] = 1'b1;
        ve[0] = {{9'h080, 9'h181, 9'h1FF, 9'h000}, 4'b0001, 4'b0110};
        ve[1] = {{9'h000, 9'h005, 9'h080, 9'h001}, 4'b1000, 4'b0000};
        ve[2] = {{9'h1F0, 9'h010, 9'h101, 9'h0FF}, 4'b0000, 4'b1010};
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            din = vd[i]; mode = vm[i]; mask = vk[i];
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if ((vu[i] ? in_ready_u : in_ready) !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_ready got 0 exp 1", i);
            end
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ((vu[i] ? out_valid_u : out_valid) !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_early_valid got 1 exp 0", i);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ((vu[i] ? out_valid_u : out_valid) !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_latency got 0 exp 1", i);
            end
            got = vu[i] ? {dout_u, zero_u, sign_u} : {dout, zero, sign};
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL vec%0d_result got %h exp %h", i, got, ve[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stream(input int n, input bit rnd);
        beat_t qs[$];
        beat_t qu[$];
        beat_t e;
        beat_t hold;
        int    sent, got, cyc, occ;
        bit    stalled, acc;
        sent = 0; got = 0; cyc = 0; occ = 0;
        stalled = 1'b0; acc = 1'b1; hold = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (got < n && cyc < 3000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
            if (!in_valid || acc) begin
                if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1;
                    din  = $urandom();
                    mode = 2'($urandom_range(0, 3));
                    mask = 4'($urandom_range(0, 15));
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            checks++;
            if (in_ready !== ((occ < ST) || out_ready)) begin
                errors++;
                $display("FAIL stream_in_ready got %b exp %b occ=%0d", in_ready,
                         ((occ < ST) || out_ready), occ);
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {dout, zero, sign} !== hold) begin
                    errors++;
                    $display("FAIL stream_hold got %b/%h exp 1/%h", out_valid,
                             {dout, zero, sign}, hold);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (qs.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got beat %h exp none", {dout, zero, sign});
                end else begin
                    e = qs.pop_front();
                    if ({dout, zero, sign} !== e) begin
                        errors++;
                        $display("FAIL stream_data got %h exp %h", {dout, zero, sign}, e);
                    end
                end
                got++;
                occ--;
            end
            if (out_valid_u && out_ready) begin
                checks++;
                if (qu.size() == 0) begin
                    errors++;
                    $display("FAIL ustream_extra got beat %h exp none", {dout_u, zero_u, sign_u});
                end else begin
                    e = qu.pop_front();
                    if ({dout_u, zero_u, sign_u} !== e) begin
                        errors++;
                        $display("FAIL ustream_data got %h exp %h", {dout_u, zero_u, sign_u}, e);
                    end
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                qs.push_back(ref_beat(din, mode, mask, 1'b1));
                sent++;
                occ++;
            end
            if (in_valid && in_ready_u) qu.push_back(ref_beat(din, mode, mask, 1'b0));
            stalled = out_valid && !out_ready;
            hold = {dout, zero, sign};
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL stream_timeout got %0d beats exp %0d", got, n);
        end
        checks++;
        if (qu.size() != 0) begin
            errors++;
            $display("FAIL ustream_left got %0d pending exp 0", qu.size());
        end
    endtask

    task automatic test_flush;
        beat_t e;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        din = $urandom(); mode = 2'b01;
        @(posedge clk); #1 din = $urandom();
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
        end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b exp 0", in_ready);
        end
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_cleared%0d got 1 exp 0", i);
            end
            @(posedge clk); #1;
        end
        din = $urandom(); mode = 2'b10; mask = '0;
        e = ref_beat(din, mode, mask, 1'b1);
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_early got 1 exp 0");
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || {dout, zero, sign} !== e) begin
            errors++;
            $display("FAIL flush_next got %b/%h exp 1/%h", out_valid, {dout, zero, sign}, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        beat_t e;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        din = 32'h80FF0180; mode = 2'b01;
        @(posedge clk); #1 din = 32'h7F7F7F7F;
        @(posedge clk); #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== '0 || zero !== '0 || sign !== '0) begin
            errors++;
            $display("FAIL areset_outputs got v=%b d=%h z=%b s=%b exp all 0",
                     out_valid, dout, zero, sign);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        din = $urandom(); mode = 2'b11; mask = 4'($urandom_range(0, 15));
        e = ref_beat(din, mode, mask, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_ready got 0 exp 1");
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_early got 1 exp 0");
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || {dout, zero, sign} !== e) begin
            errors++;
            $display("FAIL areset_latency got %b/%h exp 1/%h", out_valid, {dout, zero, sign}, e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stream(8, 1'b0);
        test_stream(120, 1'b1);
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
